eth_tx_length_framer: RTL and testbench
=======================================

ETH_TX_LENGTH_FRAMER -- requirements
Module: eth_tx_length_framer

Interface
REQ-001 Parameter LENGTH_WIDTH, 11, width of length descriptor.
REQ-002 Parameter MAX_LENGTH, 1522, largest legal descriptor value in bytes.
REQ-003 tx_clk  input  1  clock; all logic on rising edge.
REQ-004 tx_rst  input  1  reset, asynchronous, active-high.
REQ-005 s_len_tdata  input  LENGTH_WIDTH  frame length in bytes.
REQ-006 s_len_tvalid / s_len_tready  input / output  1 / 1  descriptor handshake.
REQ-007 s_axis_tdata  input  8  source byte stream.
REQ-008 s_axis_tvalid, s_axis_tlast, s_axis_tuser / s_axis_tready  input / output  1 each  source handshake, end, bad-frame flag.
REQ-009 m_axis_tdata  output  8  byte to MAC TX.
REQ-010 m_axis_tvalid, m_axis_tlast, m_axis_tuser / m_axis_tready  output / input  1 each  MAC-side handshake; tuser=1 marks bad frame.
REQ-011 len_err, early_last_err, late_last_err  output  1 each  single-cycle error pulses.
REQ-012 good_frame_count  output  16  count of frames emitted with tuser=0.

Function
REQ-013 States IDLE, DATA, DRAIN; reset state IDLE.
REQ-014 IDLE: s_len_tready=1, s_axis_tready=0; on descriptor handshake with 1 <= len <= MAX_LENGTH load remaining=len, go DATA.
REQ-015 IDLE: descriptor len==0 or len>MAX_LENGTH: consume it, pulse len_err next cycle, go DRAIN.
REQ-016 DATA: s_len_tready=0; s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register, 1-cycle latency, full throughput).
REQ-017 DATA transfer with remaining>1 and s_axis_tlast=0: forward byte, tlast=0, tuser=0, remaining decrements by 1.
REQ-018 DATA transfer with remaining==1 and s_axis_tlast=1: forward byte, tlast=1, tuser=s_axis_tuser, go IDLE.
REQ-019 DATA transfer with remaining==1 and s_axis_tlast=0: forward byte, tlast=1, tuser=1, pulse late_last_err, go DRAIN.
REQ-020 DATA transfer with remaining>1 and s_axis_tlast=1: forward byte, tlast=1, tuser=1, pulse early_last_err, go IDLE.
REQ-021 DRAIN: s_axis_tready=1, nothing forwarded, m_axis_tvalid unaffected by drained bytes; on accepted s_axis_tlast go IDLE.
REQ-022 Output register holds data stable while m_axis_tvalid=1 and m_axis_tready=0; m_axis_tvalid clears on m_axis_tready with no new transfer.
REQ-023 IDLE accepts next descriptor while last byte of previous frame still waits in output register.
REQ-024 good_frame_count increments by 1 when output tlast=1, tuser=0 is loaded; wraps 0xFFFF to 0x0000.
REQ-025 remaining is LENGTH_WIDTH bits; no decrement below 1 occurs by construction.
REQ-026 Error pulses are mutually exclusive, one cycle, registered.

Reset
REQ-027 On tx_rst: state IDLE, remaining 0, m_axis_tvalid/tlast/tuser 0, m_axis_tdata 0, error pulses 0, good_frame_count 0.
REQ-028 Reset mid-frame abandons partial frame; no tlast emitted for it; first post-reset descriptor starts a clean frame.

Structure
REQ-029 Shared package eth_tx_pkg holds LENGTH_WIDTH, MAX_LENGTH defaults and the state enum type.
REQ-030 No sub-module; state machine, counter and output register inline in one module.

Verification
REQ-031 len=64, 64 source bytes, tlast on byte 64, m_axis_tready=1 -> 64 bytes out, tlast on 64th, tuser=0, count 0->1, no error pulse.
REQ-032 len=60, source tlast on byte 40 -> 40 bytes out, tlast+tuser=1 on 40th, early_last_err one pulse, IDLE after.
REQ-033 len=10, source frame 16 bytes -> 10 bytes out, tlast+tuser=1 on 10th, late_last_err, bytes 11-16 discarded, next frame 64/64 clean.
REQ-034 len=0 then len=1600, each followed by a 20-byte frame -> two len_err pulses, zero output bytes, count unchanged.
REQ-035 len=64, m_axis_tready toggled 1/0 random 50% -> byte order and data identical to source, no byte lost or duplicated.
REQ-036 tx_rst asserted after byte 30 of len=100 -> outputs 0 immediately, then len=64 frame passes clean, count=1.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet TX length framer.
// Default descriptor sizing and the framer state encoding.
package eth_tx_pkg;

    localparam int LENGTH_WIDTH_DEF = 11;
    localparam int MAX_LENGTH_DEF   = 1522;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/eth_tx_length_framer.sv
// Ethernet TX length framer: trims or flags a byte stream so each
// emitted frame matches its length descriptor exactly.
module eth_tx_length_framer
    import eth_tx_pkg::*;
#(
    parameter int LENGTH_WIDTH = LENGTH_WIDTH_DEF,
    parameter int MAX_LENGTH   = MAX_LENGTH_DEF
) (
    input  logic                    tx_clk,
    input  logic                    tx_rst,
    input  logic [LENGTH_WIDTH-1:0] s_len_tdata,
    input  logic                    s_len_tvalid,
    output logic                    s_len_tready,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    s_axis_tready,
    output logic [7:0]              m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic                    len_err,
    output logic                    early_last_err,
    output logic                    late_last_err,
    output logic [15:0]             good_frame_count
);

    localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_LENGTH);
    localparam logic [LENGTH_WIDTH-1:0] ONE     = LENGTH_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
    logic [7:0]              tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic                    len_err_q, len_err_d;
    logic                    early_q, early_d;
    logic                    late_q, late_d;
    logic [15:0]             cnt_q, cnt_d;

    logic len_fire;
    logic len_ok;
    logic out_ready;
    logic data_fire;
    logic last_rem;

    assign len_fire  = s_len_tvalid && s_len_tready;
    assign len_ok    = (s_len_tdata != '0) && (s_len_tdata <= MAX_LEN);
    assign out_ready = !tvalid_q || m_axis_tready;
    assign data_fire = (state_q == ST_DATA) && s_axis_tvalid && out_ready;
    assign last_rem  = (rem_q == ONE);

    // State register.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from descriptor and stream events.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (len_fire) begin
                    state_d = len_ok ? ST_DATA : ST_DRAIN;
                end
            end
            ST_DATA: begin
                if (data_fire) begin
                    if (last_rem) begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake readies decoded from the current state.
    always_comb begin
        s_len_tready  = 1'b0;
        s_axis_tready = 1'b0;
        unique case (state_q)
            ST_IDLE:  s_len_tready  = 1'b1;
            ST_DATA:  s_axis_tready = out_ready;
            ST_DRAIN: s_axis_tready = 1'b1;
            default: begin
                s_len_tready  = 1'b0;
                s_axis_tready = 1'b0;
            end
        endcase
    end

    // Datapath next values: byte counter, output register, error pulses.
    always_comb begin
        rem_d     = rem_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;
        len_err_d = len_fire && !len_ok;
        early_d   = data_fire && !last_rem && s_axis_tlast;
        late_d    = data_fire && last_rem && !s_axis_tlast;
        cnt_d     = cnt_q;

        if (len_fire && len_ok) begin
            rem_d = s_len_tdata;
        end

        if (data_fire) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            tlast_d  = last_rem || s_axis_tlast;
            if (last_rem) begin
                tuser_d = s_axis_tlast ? s_axis_tuser : 1'b1;
            end else begin
                tuser_d = s_axis_tlast;
            end
            if (!last_rem) begin
                rem_d = rem_q - ONE;
            end
            if (last_rem && s_axis_tlast && !s_axis_tuser) begin
                cnt_d = cnt_q + 16'd1;
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            rem_q     <= '0;
            tdata_q   <= 8'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            len_err_q <= 1'b0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
            cnt_q     <= 16'd0;
        end else begin
            rem_q     <= rem_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            len_err_q <= len_err_d;
            early_q   <= early_d;
            late_q    <= late_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign len_err          = len_err_q;
    assign early_last_err   = early_q;
    assign late_last_err    = late_q;
    assign good_frame_count = cnt_q;

endmodule

// File: tb/tb_eth_tx_length_framer.sv
// Scoreboard bench for eth_tx_length_framer.
// Expected bytes are queued by the driver and popped at MAC handshakes.
module tb_eth_tx_length_framer;

    localparam int MAXL = 1522;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } exp_t;

    logic        tx_clk = 1'b0;
    logic        tx_rst = 1'b1;
    logic [10:0] s_len_tdata = '0;
    logic        s_len_tvalid = 1'b0;
    logic        s_len_tready;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b1;
    logic        len_err;
    logic        early_last_err;
    logic        late_last_err;
    logic [15:0] good_frame_count;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   obs_len = 0, obs_early = 0, obs_late = 0;
    int   exp_len = 0, exp_early = 0, exp_late = 0;
    int   exp_good = 0;
    bit   rand_rdy = 1'b0;

    eth_tx_length_framer dut (
        .tx_clk           (tx_clk),
        .tx_rst           (tx_rst),
        .s_len_tdata      (s_len_tdata),
        .s_len_tvalid     (s_len_tvalid),
        .s_len_tready     (s_len_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .len_err          (len_err),
        .early_last_err   (early_last_err),
        .late_last_err    (late_last_err),
        .good_frame_count (good_frame_count)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MAC-side sink: compare every handshaken byte, tally error pulses.
    always @(negedge tx_clk) begin
        if (!tx_rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tdata", 32'(m_axis_tdata), 32'(e.d));
                    chk("tlast", 32'(m_axis_tlast), 32'(e.l));
                    chk("tuser", 32'(m_axis_tuser), 32'(e.u));
                end
            end
            if (len_err || early_last_err || late_last_err) begin
                chk("err_onehot",
                    32'(len_err) + 32'(early_last_err) + 32'(late_last_err),
                    32'd1);
                if (len_err) obs_len++;
                if (early_last_err) obs_early++;
                if (late_last_err) obs_late++;
            end
        end
    end

    // Ready pattern for the MAC side.
    initial begin
        forever begin
            @(posedge tx_clk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_desc(input int len);
        bit r;
        int t;
        s_len_tdata  = 11'(len);
        s_len_tvalid = 1'b1;
        r = 1'b0;
        for (t = 0; t < 500 && !r; t++) begin
            @(negedge tx_clk);
            r = s_len_tready;
            @(posedge tx_clk);
            #1;
        end
        if (!r) chk("desc_timeout", 32'd0, 32'd1);
        s_len_tvalid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l,
                             input logic u);
        bit r;
        int t;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        s_axis_tvalid = 1'b1;
        r = 1'b0;
        for (t = 0; t < 500 && !r; t++) begin
            @(negedge tx_clk);
            r = s_axis_tready;
            @(posedge tx_clk);
            #1;
        end
        if (!r) chk("src_timeout", 32'd0, 32'd1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Queue the expected MAC output, then drive descriptor and bytes.
    task automatic send_frame(input int len, input int nsrc,
                              input bit bad, input int seed);
        int n;
        if (len == 0 || len > MAXL) begin
            exp_len++;
        end else begin
            n = (len < nsrc) ? len : nsrc;
            for (int i = 0; i < n; i++) begin
                exp_t e;
                e.d = 8'(seed + i);
                e.l = (i == n - 1);
                e.u = (i == n - 1) ? ((nsrc == len) ? bad : 1'b1) : 1'b0;
                sb.push_back(e);
            end
            if (nsrc > len) exp_late++;
            else if (nsrc < len) exp_early++;
            else if (!bad) exp_good++;
        end
        send_desc(len);
        for (int i = 0; i < nsrc; i++) begin
            send_byte(8'(seed + i), i == nsrc - 1,
                      (i == nsrc - 1) ? bad : 1'b0);
        end
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < 2000 && sb.size() != 0; i++) begin
            @(posedge tx_clk);
        end
        repeat (4) @(posedge tx_clk);
        #1;
        chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
        chk({tag, "_len_err"}, 32'(obs_len), 32'(exp_len));
        chk({tag, "_early"}, 32'(obs_early), 32'(exp_early));
        chk({tag, "_late"}, 32'(obs_late), 32'(exp_late));
        chk({tag, "_good"}, 32'(good_frame_count), 32'(exp_good));
    endtask

    initial begin
        repeat (3) @(posedge tx_clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_count", 32'(good_frame_count), 32'd0);
        chk("rst_errs", 32'({len_err, early_last_err, late_last_err}), 32'd0);
        tx_rst = 1'b0;
        @(posedge tx_clk);
        #1;
        chk("idle_len_rdy", 32'(s_len_tready), 32'd1);
        chk("idle_src_rdy", 32'(s_axis_tready), 32'd0);

        send_frame(64, 64, 1'b0, 8'h10);
        settle("clean64");

        send_frame(60, 40, 1'b0, 8'h40);
        settle("early");

        send_frame(10, 16, 1'b0, 8'h80);
        send_frame(64, 64, 1'b0, 8'hA0);
        settle("late");

        send_frame(0, 20, 1'b0, 8'h01);
        send_frame(1600, 20, 1'b0, 8'h02);
        settle("badlen");

        send_frame(1, 1, 1'b0, 8'h33);
        send_frame(3, 3, 1'b1, 8'h44);
        settle("short");

        rand_rdy = 1'b1;
        send_frame(64, 64, 1'b0, 8'hC0);
        send_frame(MAXL, MAXL, 1'b0, 8'h07);
        settle("bp");
        rand_rdy = 1'b0;

        send_desc(100);
        for (int i = 0; i < 30; i++) begin
            exp_t e;
            e.d = 8'(8'h55 + i);
            e.l = 1'b0;
            e.u = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 30; i++) begin
            send_byte(8'(8'h55 + i), 1'b0, 1'b0);
        end
        tx_rst = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("midrst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("midrst_count", 32'(good_frame_count), 32'd0);
        chk("midrst_len_rdy", 32'(s_len_tready), 32'd1);
        sb.delete();
        exp_good = 0;
        @(posedge tx_clk);
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        send_frame(64, 64, 1'b0, 8'hE0);
        settle("postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
